// File: rtl/match_pkg.sv
// Shared types and constants for the match window counter.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic SEL_NEQ = 1'b0;
  localparam logic SEL_EQ  = 1'b1;

endpackage

// File: rtl/pair_match.sv
// Combinational pair evaluation: equality when sel is SEL_EQ, inequality otherwise.
module pair_match
  import match_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             match
);

  // Select between equal and unequal comparison of the operand pair.
  always_comb begin
    match = (sel == SEL_EQ) ? (a == b) : (a != b);
  end

endmodule

// File: rtl/match_window_counter.sv
// Counts matching operand pairs over a window of WINDOW accepted pairs and
// presents a held summary over a valid/ready handshake.
// Optional build macro MATCH_HISTORY_EN adds out_hist, the per-pair match
// bits of the reported window (bit 0 = first accepted pair).
//
//   state  | meaning
//   IDLE   | no pairs accepted in the current window
//   ACCUM  | 1..WINDOW-1 pairs accepted
//   REPORT | window complete, summary held until out_ready
module match_window_counter
  import match_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int WINDOW = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all,
  output logic             out_none
`ifdef MATCH_HISTORY_EN
  ,
  output logic [WINDOW-1:0] out_hist
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             match;
  logic             accept;
  logic             last;
  logic             handoff;

  pair_match #(.WIDTH(WIDTH)) u_pair_match (
    .a     (a),
    .b     (b),
    .sel   (sel),
    .match (match)
  );

  assign accept  = in_valid && in_ready;
  assign last    = (idx == CNT_W'(WINDOW - 1));
  assign handoff = (state == REPORT) && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; clr overrides any handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = !clr;
        if (in_valid && !clr) state_nxt = last ? REPORT : ACCUM;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // Pair index and match count; held through REPORT, cleared on handoff.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
      cnt <= '0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      cnt <= cnt + CNT_W'(match);
    end else if (handoff) begin
      idx <= '0;
      cnt <= '0;
    end
  end

  // Summary is only meaningful while reporting; zero otherwise.
  always_comb begin
    out_count = (state == REPORT) ? cnt : '0;
    out_all   = (state == REPORT) && (cnt == CNT_W'(WINDOW));
    out_none  = (state == REPORT) && (cnt == '0);
  end

`ifdef MATCH_HISTORY_EN
  logic [WINDOW-1:0] hist;

  // Per-pair match bits, placed at the pair's position within the window.
  always_ff @(posedge clk) begin
    if (rst || clr)   hist <= '0;
    else if (accept)  hist <= hist | (WINDOW'(match) << idx);
    else if (handoff) hist <= '0;
  end

  assign out_hist = (state == REPORT) ? hist : '0;
`endif

endmodule

// File: tb/tb_match_window_counter.sv
// Directed self-checking bench for match_window_counter (WIDTH=4, WINDOW=8).
module tb_match_window_counter;
  import match_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       sel = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_count;
  logic       out_all;
  logic       out_none;
`ifdef MATCH_HISTORY_EN
  logic [7:0] out_hist;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rises   = 0;
  logic ov_q  = 1'b0;

  match_window_counter #(.WIDTH(4), .WINDOW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_none  (out_none)
`ifdef MATCH_HISTORY_EN
    ,
    .out_hist  (out_hist)
`endif
  );

  always #5 clk = ~clk;

  // Count rising edges of out_valid, sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid && !ov_q) rises++;
    ov_q = out_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic vs);
    in_valid = 1'b1;
    a = va;
    b = vb;
    sel = vs;
    tick();
  endtask

  task automatic handoff();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_valid", 32'(out_valid), 0);
    chk("handoff_ready", 32'(in_ready), 1);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_none", 32'(out_none), 0);
    chk("rst_all", 32'(out_all), 0);

    // All equal, back-to-back
    for (int i = 0; i < 7; i++) send(4'b1010, 4'b1010, SEL_EQ);
    chk("eq_early_valid", 32'(out_valid), 0);
    send(4'b1010, 4'b1010, SEL_EQ);
    in_valid = 1'b0;
    chk("eq_valid", 32'(out_valid), 1);
    chk("eq_in_ready", 32'(in_ready), 0);
    chk("eq_count", 32'(out_count), 8);
    chk("eq_all", 32'(out_all), 1);
    chk("eq_none", 32'(out_none), 0);
`ifdef MATCH_HISTORY_EN
    chk("eq_hist", 32'(out_hist), 32'hFF);
`endif
    handoff();

    // Mixed: 4 unequal (match under sel=0), then 4 equal (no match)
    for (int i = 0; i < 4; i++) send(4'b1100, 4'b1001, SEL_NEQ);
    for (int i = 0; i < 4; i++) send(4'b0000, 4'b0000, SEL_NEQ);
    chk("mix_valid", 32'(out_valid), 1);
    chk("mix_count", 32'(out_count), 4);
    chk("mix_all", 32'(out_all), 0);
    chk("mix_none", 32'(out_none), 0);
`ifdef MATCH_HISTORY_EN
    chk("mix_hist", 32'(out_hist), 32'h0F);
`endif

    // Backpressure with upstream pushing a matching pair
    in_valid = 1'b1;
    a = 4'h5;
    b = 4'h5;
    sel = SEL_EQ;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_count", 32'(out_count), 4);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    // Held pair is accepted now as first of the new window; then 7 non-matching
    tick();
    for (int i = 0; i < 7; i++) send(4'h1, 4'h2, SEL_EQ);
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_count", 32'(out_count), 1);
`ifdef MATCH_HISTORY_EN
    chk("bp_next_hist", 32'(out_hist), 32'h01);
`endif
    handoff();

    // Abort after 3 accepts, clr alongside in_valid
    for (int i = 0; i < 3; i++) send(4'h7, 4'h7, SEL_EQ);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) send(4'b1111, 4'b0000, SEL_EQ);
    chk("clr_early_valid", 32'(out_valid), 0);
    send(4'b1111, 4'b0000, SEL_EQ);
    in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 1);
    chk("clr_count", 32'(out_count), 0);
    chk("clr_none", 32'(out_none), 1);
    chk("clr_all", 32'(out_all), 0);
`ifdef MATCH_HISTORY_EN
    chk("clr_hist", 32'(out_hist), 32'h00);
`endif
    handoff();

    // Gaps: in_valid every other cycle
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      send(4'h3, 4'h3, SEL_EQ);
      in_valid = 1'b0;
      if (i < 7) begin
        chk("gap_valid_low", 32'(out_valid), 0);
        tick();
      end
    end
    chk("gap_valid", 32'(out_valid), 1);
    chk("gap_count", 32'(out_count), 8);
    tick();
    tick();
    handoff();
    tick();
    tick();
    chk("gap_report_once", 32'(rises), 1);

    // Reset while reporting discards the summary
    for (int i = 0; i < 8; i++) send(4'h2, 4'h2, SEL_EQ);
    in_valid = 1'b0;
    chk("rst_mid_pre", 32'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_count", 32'(out_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
